// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with tear-free double-buffered glyph store
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  shadow buffer write (glyph code {dp,g,f,e,d,c,b,a}, active-low, 0xFF = blank)
//   frame_load       request shadow -> active commit at the next frame boundary
//   blink_mask       per-digit blink enable
//   brightness       PWM level, 0 = dimmest, 15 = full
//   seg_out, seg_an  segment and anode pins (registered, polarity set by parameters)
//   frame_done       one-cycle pulse after a commit

module seg_scan_ctrl #(
    parameter int N_DIG        = 8,
    parameter int SCAN_DIV     = 65536,
    parameter int BLANK_CYC    = 256,
    parameter int BLINK_DIV    = 50000000,
    parameter int SEG_ACT_HIGH = 1,
    parameter int AN_ACT_LOW   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(N_DIG)-1:0]   wr_addr,
    input  logic [7:0]                 wr_data,
    input  logic                       frame_load,
    input  logic [N_DIG-1:0]           blink_mask,
    input  logic [3:0]                 brightness,
    output logic [7:0]                 seg_out,
    output logic [N_DIG-1:0]           seg_an,
    output logic                       frame_done
);

    localparam int DW      = $clog2(N_DIG);
    localparam int SW      = $clog2(SCAN_DIV);
    localparam int BW      = $clog2(BLINK_DIV);
    // Lit time per brightness step; the (SCAN_DIV-BLANK_CYC)%16 leftover stays dark.
    localparam int ON_STEP = (SCAN_DIV - BLANK_CYC) / 16;

    // Idle pin levels and the segment inversion mask, derived from pin polarity.
    localparam logic [N_DIG-1:0] AN_IDLE = {N_DIG{AN_ACT_LOW != 0}};
    localparam logic [7:0]       SEG_OFF = {8{SEG_ACT_HIGH == 0}};
    localparam logic [7:0]       SEG_INV = {8{SEG_ACT_HIGH != 0}};

    logic [SW-1:0]    slot_cnt;
    logic [DW-1:0]    dig_idx;
    logic [BW-1:0]    blink_cnt;
    logic             blink_phase;
    logic             pending;
    logic [7:0]       shadow [N_DIG];
    logic [7:0]       active [N_DIG];

    logic             slot_wrap;
    logic             frame_boundary;
    logic             commit;
    logic [7:0]       cur_glyph;
    logic [N_DIG-1:0] an_sel;
    logic             in_window;
    logic             lit;
    int               lit_end;

    assign slot_wrap      = (slot_cnt == SW'(SCAN_DIV - 1));
    assign frame_boundary = slot_wrap && (dig_idx == DW'(N_DIG - 1));
    // Only a request already registered before the boundary commits on it.
    assign commit         = frame_boundary && pending;
    assign cur_glyph      = active[dig_idx];

    always_comb begin
        an_sel          = '0;
        an_sel[dig_idx] = 1'b1;
        lit_end         = BLANK_CYC + (int'(brightness) + 1) * ON_STEP;
        in_window       = (int'(slot_cnt) >= BLANK_CYC) && (int'(slot_cnt) < lit_end);
        lit             = in_window && !(blink_phase && blink_mask[dig_idx]) && (cur_glyph != 8'hFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            dig_idx  <= (dig_idx == DW'(N_DIG - 1)) ? '0 : dig_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Blink timebase runs freely, unrelated to the scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Commit wins over a simultaneous frame_load: that request was already covered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (commit) begin
            pending <= 1'b0;
        end else if (frame_load) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIG; i++) shadow[i] <= 8'hFF;
        end else if (wr_en && (int'(wr_addr) < N_DIG)) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    // Copies the pre-edge shadow, so a write on the commit edge waits for the next commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIG; i++) active[i] <= 8'hFF;
        end else if (commit) begin
            for (int i = 0; i < N_DIG; i++) active[i] <= shadow[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_an     <= AN_IDLE;
            seg_out    <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= commit;
            if (lit) begin
                seg_an  <= an_sel ^ AN_IDLE;
                seg_out <= cur_glyph ^ SEG_INV;
            end else begin
                seg_an  <= AN_IDLE;
                seg_out <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl

module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int SDIV  = 36;
    localparam int BLANK = 4;
    localparam int BDIV  = 200;
    localparam int STEP  = 2;
    localparam int FRAME = ND * SDIV;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_load;
    logic [3:0] blink_mask;
    logic [3:0] brightness;
    logic [7:0] seg_out;
    logic [3:0] seg_an;
    logic       frame_done;

    seg_scan_ctrl #(
        .N_DIG(ND), .SCAN_DIV(SDIV), .BLANK_CYC(BLANK), .BLINK_DIV(BDIV),
        .SEG_ACT_HIGH(1), .AN_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_load(frame_load), .blink_mask(blink_mask), .brightness(brightness),
        .seg_out(seg_out), .seg_an(seg_an), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    // Reference model: scan position derived from k, the index of the next rising edge since reset release.
    int         k;
    logic       m_pend;
    logic [7:0] m_shadow [ND];
    logic [7:0] m_active [ND];
    logic [12:0] q [$];

    function automatic logic is_bnd(int kk);
        return (kk % FRAME) == FRAME - 1;
    endfunction

    function automatic logic [12:0] model_out(int kk, logic fd, logic [7:0] g,
                                              logic [3:0] bri, logic [3:0] bm);
        int s, d;
        logic bp, lit;
        logic [3:0] an;
        s   = kk % SDIV;
        d   = (kk / SDIV) % ND;
        bp  = ((kk / BDIV) % 2) == 1;
        lit = (s >= BLANK) && (s < BLANK + (int'(bri) + 1) * STEP) && !(bp && bm[d]) && (g != 8'hFF);
        an  = 4'b0001 << d;
        return {fd, lit ? ~an : 4'hF, lit ? ~g : 8'h00};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            k      <= 0;
            m_pend <= 1'b0;
            for (int i = 0; i < ND; i++) begin
                m_shadow[i] <= 8'hFF;
                m_active[i] <= 8'hFF;
            end
        end else begin
            q.push_back(model_out(k, is_bnd(k) && m_pend, m_active[(k / SDIV) % ND], brightness, blink_mask));
            if (is_bnd(k) && m_pend) begin
                for (int i = 0; i < ND; i++) m_active[i] <= m_shadow[i];
                m_pend <= 1'b0;
            end else if (frame_load) begin
                m_pend <= 1'b1;
            end
            if (wr_en) m_shadow[wr_addr] <= wr_data;
            k <= k + 1;
        end
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            logic [12:0] e;
            e = q.pop_front();
            checks++;
            if ({frame_done, seg_an, seg_out} !== e) begin
                errors++;
                $display("FAIL scan k=%0d got fd/an/seg=%h expected %h", k, {frame_done, seg_an, seg_out}, e);
            end
        end
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic go_to(input int n);
        while (k < n) @(negedge clk);
    endtask

    task automatic count_an(input logic [3:0] pat, input int n, output int cnt, output int first);
        cnt   = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (seg_an === pat) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
    endtask

    function automatic int next_slot(int from, int slot_off, int phase);
        for (int t = from; t < from + 4000; t++)
            if ((t % FRAME) == slot_off && ((t / BDIV) % 2) == phase && (((t + SDIV - 1) / BDIV) % 2) == phase)
                return t;
        return from;
    endfunction

    function automatic int next_frame(int from);
        return ((from + FRAME - 1) / FRAME) * FRAME;
    endfunction

    typedef struct {
        logic [3:0] bri;
        int         exp_on;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [4];
        int   cnt, first, cnt1, first1, fd0, t, b, lit_cnt;
        logic [7:0] glyphs [4];

        tbl[0] = '{bri: 4'd0,  exp_on: 2};
        tbl[1] = '{bri: 4'd7,  exp_on: 16};
        tbl[2] = '{bri: 4'd3,  exp_on: 8};
        tbl[3] = '{bri: 4'd15, exp_on: 32};
        glyphs[0] = 8'hC0; glyphs[1] = 8'hF9; glyphs[2] = 8'hA4; glyphs[3] = 8'hB0;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        frame_load = 1'b0; blink_mask = '0; brightness = 4'd15;

        repeat (10) begin
            @(negedge clk);
            check("reset_outputs", {frame_done, seg_an, seg_out}, {1'b0, 4'hF, 8'h00});
        end
        rst_n = 1'b1;

        // Load shadow and request a commit mid-frame.
        for (int i = 0; i < ND; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_data = glyphs[i];
            @(negedge clk);
        end
        wr_en = 1'b0;
        go_to(50);
        fd0 = fd_cnt;
        frame_load = 1'b1;
        @(negedge clk);
        frame_load = 1'b0;
        go_to(FRAME - 1);
        check("no_commit_before_boundary", {seg_an, 4'(fd_cnt - fd0)}, {4'hF, 4'd0});
        go_to(FRAME + 5);
        check("frame_done_once", fd_cnt - fd0, 1);
        check("digit0_an", seg_an, 4'hE);
        check("digit0_seg", seg_out, 8'h3F);
        go_to(FRAME + SDIV + 5);
        check("digit1_an", seg_an, 4'hD);
        check("digit1_seg", seg_out, 8'h06);

        // Brightness table: lit width and dead-time at the start of each slot.
        foreach (tbl[i]) begin
            go_to(next_frame(k + 1));
            brightness = tbl[i].bri;
            count_an(4'hE, SDIV, cnt, first);
            count_an(4'hD, SDIV, cnt1, first1);
            check($sformatf("on_width_bri%0d", tbl[i].bri), cnt, tbl[i].exp_on);
            check($sformatf("dead_d0_bri%0d", tbl[i].bri), first, BLANK);
            check($sformatf("dead_d1_bri%0d", tbl[i].bri), first1, BLANK);
        end

        // Blink on digit 1 only.
        brightness = 4'd15;
        blink_mask = 4'b0010;
        t = next_slot(k + 1, SDIV, 1);
        go_to(t);
        count_an(4'hD, SDIV, cnt, first);
        check("blink_d1_dark", cnt, 0);
        t = next_slot(k + 1, 0, 1);
        go_to(t);
        count_an(4'hE, SDIV, cnt, first);
        check("blink_d0_unaffected", cnt, 32);
        t = next_slot(k + 1, SDIV, 0);
        go_to(t);
        count_an(4'hD, SDIV, cnt, first);
        check("blink_d1_lit", cnt, 32);
        blink_mask = 4'b0000;

        // frame_load and a write on the boundary cycle itself.
        b = next_frame(k + 1) + FRAME - 1;
        go_to(b);
        fd0 = fd_cnt;
        frame_load = 1'b1; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h88;
        @(negedge clk);
        frame_load = 1'b0; wr_en = 1'b0;
        go_to(b + 2);
        check("boundary_load_no_commit", fd_cnt - fd0, 0);
        go_to(b + 1 + 2 * SDIV + 5);
        check("digit2_old_glyph", {seg_an, seg_out}, {4'hB, 8'h5B});
        go_to(b + FRAME + 2);
        check("boundary_load_commit_next", fd_cnt - fd0, 1);
        go_to(b + 1 + FRAME + 2 * SDIV + 5);
        check("digit2_new_glyph", {seg_an, seg_out}, {4'hB, 8'h77});

        // Asynchronous reset while digit 2 is lit.
        t = next_frame(k + 1) + 2 * SDIV + 10;
        go_to(t);
        check("digit2_lit_before_reset", seg_an, 4'hB);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {frame_done, seg_an, seg_out}, {1'b0, 4'hF, 8'h00});
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        lit_cnt = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (seg_an !== 4'hF) lit_cnt++;
        end
        check("dark_after_reset", lit_cnt, 0);
        frame_load = 1'b1;
        @(negedge clk);
        frame_load = 1'b0;
        go_to(3 * FRAME);
        lit_cnt = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (seg_an !== 4'hF) lit_cnt++;
        end
        check("shadow_blank_after_reset", lit_cnt, 0);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hC0;
        @(negedge clk);
        wr_en = 1'b0; frame_load = 1'b1;
        @(negedge clk);
        frame_load = 1'b0;
        go_to(5 * FRAME);
        count_an(4'hE, SDIV, cnt, first);
        check("restart_digit0_width", cnt, 32);
        check("restart_digit0_first", first, BLANK);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Parametrised multiplexed 7-segment scan controller for CalcKit. It holds a double-buffered glyph store: a shadow buffer that the FSM/display formatter writes, and an active buffer that is scanned. The shadow buffer is committed to the active buffer only at a frame boundary, which makes display updates tear-free. It adds inter-digit dead-time (anti-ghosting), 16-level PWM brightness, per-digit blink, and configurable segment/anode polarity. It sits between the display-formatting logic and the board segment/anode pins.

Parameters:
N_DIG, 8, number of digits scanned (2..16)
SCAN_DIV, 65536, clocks per digit slot
BLANK_CYC, 256, dead-time clocks at start of each slot (all anodes off)
BLINK_DIV, 50000000, clocks per blink half-period
SEG_ACT_HIGH, 1, 1 = segment pins lit on '1'
AN_ACT_LOW, 1, 1 = anode pins selected on '0'

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
wr_en  in  1  write shadow buffer entry
wr_addr  in  clog2(N_DIG)  shadow digit index; 0 = rightmost
wr_data  in  8  glyph, internal active-low code {dp,g,f,e,d,c,b,a}; 0xFF = blank
frame_load  in  1  request commit of shadow to active
blink_mask  in  N_DIG  1 = digit blinks
brightness  in  4  0 = dimmest, 15 = full
seg_out  out  8  segment pins, polarity per SEG_ACT_HIGH
seg_an  out  N_DIG  anode pins, polarity per AN_ACT_LOW
frame_done  out  1  one-cycle pulse when a commit occurs

Behaviour:
- Reset (async, rst_n low):
  - Both buffers are set to 0xFF.
  - slot_cnt=0, dig_idx=0, blink_phase=0, pending=0.
  - seg_an = all deselected; seg_out = all segments off; frame_done=0.
  - The same values hold immediately if reset is asserted mid-frame.
- Constraints: SCAN_DIV > BLANK_CYC. ON_STEP=(SCAN_DIV-BLANK_CYC)/16 is a localparam and must be ≥1. The remainder (SCAN_DIV-BLANK_CYC)%16 is always dark.
- Slot counter:
  - slot_cnt increments every clk and wraps at SCAN_DIV-1 to 0.
  - On the wrap, dig_idx increments, wrapping N_DIG-1 → 0.
- Frame boundary = the cycle where slot_cnt==SCAN_DIV-1 and dig_idx==N_DIG-1.
- Shadow write: when wr_en=1, shadow[wr_addr] updates on that edge. wr_addr ≥ N_DIG is ignored.
- Commit:
  - frame_load sets pending, which is sticky.
  - At a frame boundary with pending already 1: all of shadow is copied to active on that edge, pending clears, and frame_done=1 in the following cycle.
  - frame_load asserted on a boundary cycle is not yet visible, so its commit happens at the next boundary.
  - A shadow write on the commit edge is not part of the copy; it is kept for the next commit.
  - A frame_load while pending=1 has no additional effect.
- Lit window (digit d = dig_idx): lit when all of the following hold:
  - BLANK_CYC ≤ slot_cnt < BLANK_CYC + (brightness+1)*ON_STEP;
  - !(blink_phase && blink_mask[d]);
  - active[d] != 0xFF.
  - brightness is sampled every cycle, so a change takes effect mid-slot.
- Outputs: registered, one-cycle latency from slot_cnt/dig_idx.
  - Lit: seg_an selects only digit d; seg_out = SEG_ACT_HIGH ? ~active[d] : active[d].
  - Not lit: seg_an = all deselected; seg_out = all off (0x00 if SEG_ACT_HIGH, else 0xFF).
  - Never more than one anode selected.
- Blink: blink_cnt counts 0..BLINK_DIV-1; on wrap, blink_phase toggles. It is free-running and independent of scanning.

Test Plan:
1. Bench params: N_DIG=4, SCAN_DIV=36, BLANK_CYC=4 (ON_STEP=2), BLINK_DIV=200, defaults otherwise. Hold rst_n low for 10 cycles, then release → seg_an=4'hF, seg_out=8'h00 throughout reset and for the first 5 cycles after; frame_done never pulses.
2. Write shadow[0..3]=C0,F9,A4,B0, pulse frame_load mid-frame, brightness=15 → seg_an stays 4'hF until the next frame boundary; frame_done pulses exactly once. In the following digit-0 slot: seg_an=4'hE and seg_out=8'h3F for slot_cnt 4..35 (output one cycle later). Digit 1 then shows seg_an=4'hD, seg_out=8'h06.
3. brightness=0 → each lit slot has an anode active for exactly 2 cycles. brightness=7 → 16 cycles. Dead-time of 4 cycles between adjacent digits in all cases.
4. blink_mask=4'b0010 → digit 1 is dark for 200-clk windows alternating with 200-clk lit windows. Digits 0, 2, 3 are unaffected.
5. Assert frame_load and wr_en (addr 2, data 0x88) together on a frame-boundary cycle → no commit at that boundary. At the next boundary, active[2]=0x88 and frame_done pulses once.
6. Assert rst_n low mid-slot while digit 2 is lit → seg_an=4'hF and seg_out=8'h00 asynchronously. After release, scanning restarts at digit 0 with blank buffers; active and shadow remain 0xFF until a new commit.
